// File: rtl/guess_round_fsm.sv
// ---------------------------------------------------------------------------
// guess_round_fsm
//   Round controller for the number-guessing game. On an accepted start it
//   latches a secret (0..99) derived from a free-running 7-bit LFSR, loads
//   the round countdown for the selected difficulty (30/60/90 s), grades
//   player guesses and declares WIN or LOSE.
//
// Parameters
//   TICK_DIV     : clock cycles per one-second countdown tick (>= 2)
//   MAX_ATTEMPTS : graded guesses allowed per round (1..15)
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   difficulty   : 1 = 30 s, 2 = 60 s, 3 = 90 s, 0 = invalid
//   start        : single-cycle request to begin a round
//   guess_valid  : single-cycle strobe qualifying guess
//   guess        : player guess, legal range 0..99
//   time_left    : seconds remaining in the round
//   hint         : 00 none, 01 too low, 10 too high, 11 correct
//   attempts     : graded guesses made this round
//   busy/win/lose: state indicators for PLAY/WIN/LOSE
//   secret       : latched secret while in WIN/LOSE, 0 otherwise
// ---------------------------------------------------------------------------
module guess_round_fsm #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int MAX_ATTEMPTS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] difficulty,
  input  logic       start,
  input  logic       guess_valid,
  input  logic [6:0] guess,
  output logic [6:0] time_left,
  output logic [1:0] hint,
  output logic [3:0] attempts,
  output logic       busy,
  output logic       win,
  output logic       lose,
  output logic [6:0] secret
);

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

  localparam int            CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [3:0]    ATT_LAST  = 4'(MAX_ATTEMPTS);

  state_t        state, state_n;
  logic [6:0]    time_left_n;
  logic [1:0]    hint_n;
  logic [3:0]    attempts_n, attempts_inc;
  logic [6:0]    secret_q, secret_n;
  logic [CW-1:0] tick_cnt, tick_cnt_n;
  logic [6:0]    lfsr;
  logic          tick;

  // State decode comes straight off the state register, so these are
  // registered outputs with no input-to-output path.
  assign busy   = (state == PLAY);
  assign win    = (state == WIN);
  assign lose   = (state == LOSE);
  assign secret = (win || lose) ? secret_q : 7'd0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    state_n      = state;
    time_left_n  = time_left;
    hint_n       = hint;
    attempts_n   = attempts;
    secret_n     = secret_q;
    tick_cnt_n   = '0;
    tick         = 1'b0;
    attempts_inc = attempts + 4'd1;

    case (state)
      PLAY: begin
        tick       = (tick_cnt == TICK_LAST);
        tick_cnt_n = tick ? '0 : tick_cnt + CW'(1);

        // Timeout first; a correct guess below overrides LOSE with WIN,
        // while time_left still takes the final decrement to 0.
        if (tick) begin
          time_left_n = time_left - 7'd1;
          if (time_left == 7'd1) state_n = LOSE;
        end

        if (guess_valid && guess < 7'd100) begin
          attempts_n = attempts_inc;
          if (guess < secret_q)      hint_n = 2'b01;
          else if (guess > secret_q) hint_n = 2'b10;
          else                       hint_n = 2'b11;

          if (guess == secret_q)          state_n = WIN;
          else if (attempts_inc == ATT_LAST) state_n = LOSE;
        end
      end

      default: begin
        // IDLE, WIN and LOSE all accept a new round directly.
        if (start && difficulty != 2'd0) begin
          state_n    = PLAY;
          attempts_n = 4'd0;
          hint_n     = 2'b00;
          secret_n   = (lfsr >= 7'd100) ? lfsr - 7'd100 : lfsr;
          case (difficulty)
            2'd1:    time_left_n = 7'd30;
            2'd2:    time_left_n = 7'd60;
            default: time_left_n = 7'd90;
          endcase
        end
      end
    endcase
  end

  // NOTE: the async reset covers every flop, including the LFSR, so the
  // secret sequence after reset is repeatable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      time_left <= 7'd0;
      hint      <= 2'b00;
      attempts  <= 4'd0;
      secret_q  <= 7'd0;
      tick_cnt  <= '0;
      lfsr      <= 7'h01;
    end else begin
      // NOTE: non-blocking assignments so all registers update together
      // from values sampled before the edge.
      state     <= state_n;
      time_left <= time_left_n;
      hint      <= hint_n;
      attempts  <= attempts_n;
      secret_q  <= secret_n;
      tick_cnt  <= tick_cnt_n;
      // x^7 + x^6 + 1 Fibonacci; a non-zero seed never reaches all-zero.
      lfsr      <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  end

endmodule

// File: tb/tb_guess_round_fsm.sv
// ---------------------------------------------------------------------------
// tb_guess_round_fsm
//   Directed bench for guess_round_fsm with TICK_DIV = 4, MAX_ATTEMPTS = 10.
//   Expected output snapshots are queued as stimulus is driven and compared
//   after the clock edge that should produce them.
// ---------------------------------------------------------------------------
module tb_guess_round_fsm;

  localparam int TD = 4;
  localparam int MA = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] difficulty = 2'd0;
  logic       start = 1'b0;
  logic       guess_valid = 1'b0;
  logic [6:0] guess = 7'd0;
  logic [6:0] time_left;
  logic [1:0] hint;
  logic [3:0] attempts;
  logic       busy, win, lose;
  logic [6:0] secret;

  always #5 clk = ~clk;

  guess_round_fsm #(.TICK_DIV(TD), .MAX_ATTEMPTS(MA)) dut (
    .clk,
    .rst,
    .difficulty,
    .start,
    .guess_valid,
    .guess,
    .time_left,
    .hint,
    .attempts,
    .busy,
    .win,
    .lose,
    .secret
  );

  typedef struct packed {
    logic [6:0] tl;
    logic [1:0] hint;
    logic [3:0] att;
    logic       busy;
    logic       win;
    logic       lose;
    logic [6:0] secret;
  } snap_t;

  typedef struct {
    string tag;
    snap_t v;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   elapsed = 0;   // clock edges since the accepted start edge
  int   load_t  = 0;   // countdown load value of the current round

  // Reference LFSR: x^7 + x^6 + 1, seeded 7'h01, shifting every edge.
  logic [6:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 7'h01;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  function automatic logic [6:0] sec_of(input logic [6:0] v);
    return (v < 7'd100) ? v : v - 7'd100;
  endfunction

  // Countdown value expected after the next clock edge.
  function automatic logic [6:0] exp_tl();
    return 7'(load_t - (elapsed + 1) / TD);
  endfunction

  function automatic snap_t mk(input int tl, input logic [1:0] h, input int a,
                               input logic b, input logic w, input logic l,
                               input logic [6:0] s);
    snap_t r;
    r.tl = 7'(tl); r.hint = h; r.att = 4'(a);
    r.busy = b; r.win = w; r.lose = l; r.secret = s;
    return r;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("tl=%0d hint=%b att=%0d busy=%b win=%b lose=%b secret=%0d",
                     s.tl, s.hint, s.att, s.busy, s.win, s.lose, s.secret);
  endfunction

  task automatic push(input string tag, input snap_t v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check();
    snap_t obs;
    exp_t  e;
    obs.tl = time_left; obs.hint = hint; obs.att = attempts;
    obs.busy = busy; obs.win = win; obs.lose = lose; obs.secret = secret;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      assert (obs === e.v) passed++;
      else $error("FAIL %s: got %s, expected %s", e.tag, fmt(obs), fmt(e.v));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    elapsed++;
    check();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  logic [6:0] s_a, s_b, s_c, s_e, s_f, wrong, tl_frozen;
  logic [1:0] wh;

  initial begin
    // ---- reset --------------------------------------------------------
    repeat (2) @(posedge clk);
    #1;
    push("reset_state", mk(0, 2'b00, 0, 0, 0, 0, 0));
    check();
    rst = 1'b0;
    push("idle_after_reset", mk(0, 2'b00, 0, 0, 0, 0, 0));
    step();

    // ---- round A: difficulty 2, timeout -------------------------------
    difficulty = 2'd2; start = 1'b1; s_a = sec_of(m_lfsr);
    load_t = 60; elapsed = -1;
    push("start_d2", mk(60, 2'b00, 0, 1, 0, 0, 0));
    step();
    start = 1'b0;
    run(2);
    push("before_first_tick", mk(60, 2'b00, 0, 1, 0, 0, 0));
    step();
    push("first_tick", mk(59, 2'b00, 0, 1, 0, 0, 0));
    step();
    run(234);
    push("last_second", mk(1, 2'b00, 0, 1, 0, 0, 0));
    step();
    push("timeout_lose", mk(0, 2'b00, 0, 0, 0, 1, s_a));
    step();
    push("lose_holds", mk(0, 2'b00, 0, 0, 0, 1, s_a));
    step();

    // ---- round B: low / high / correct --------------------------------
    for (int i = 0; i < 300; i++) begin
      if (sec_of(m_lfsr) >= 7'd1 && sec_of(m_lfsr) <= 7'd98) break;
      step();
    end
    s_b = sec_of(m_lfsr);
    difficulty = 2'd2; start = 1'b1; load_t = 60; elapsed = -1;
    push("restart_from_lose", mk(60, 2'b00, 0, 1, 0, 0, 0));
    step();
    start = 1'b0;
    guess_valid = 1'b1; guess = s_b - 7'd1;
    push("guess_low", mk(exp_tl(), 2'b01, 1, 1, 0, 0, 0));
    step();
    guess = s_b + 7'd1;
    push("guess_high", mk(exp_tl(), 2'b10, 2, 1, 0, 0, 0));
    step();
    guess = s_b; tl_frozen = exp_tl();
    push("guess_hit", mk(tl_frozen, 2'b11, 3, 0, 1, 0, s_b));
    step();
    guess = s_b + 7'd1;
    push("win_ignores_guess", mk(tl_frozen, 2'b11, 3, 0, 1, 0, s_b));
    step();
    guess_valid = 1'b0;
    run(9);
    push("win_time_frozen", mk(tl_frozen, 2'b11, 3, 0, 1, 0, s_b));
    step();

    // ---- round C: illegal guesses, start in PLAY, ten wrong -----------
    difficulty = 2'd3; start = 1'b1; s_c = sec_of(m_lfsr);
    load_t = 90; elapsed = -1;
    push("start_d3_from_win", mk(90, 2'b00, 0, 1, 0, 0, 0));
    step();
    start = 1'b0;
    guess_valid = 1'b1; guess = 7'd100;
    push("guess_100_ignored", mk(exp_tl(), 2'b00, 0, 1, 0, 0, 0));
    step();
    guess = 7'd127;
    push("guess_127_ignored", mk(exp_tl(), 2'b00, 0, 1, 0, 0, 0));
    step();
    guess_valid = 1'b0;
    difficulty = 2'd1; start = 1'b1;
    push("start_in_play_ignored", mk(exp_tl(), 2'b00, 0, 1, 0, 0, 0));
    step();
    start = 1'b0;
    wrong = (s_c == 7'd50) ? 7'd51 : 7'd50;
    wh    = (wrong < s_c) ? 2'b01 : 2'b10;
    guess_valid = 1'b1; guess = wrong;
    for (int i = 1; i <= MA; i++) begin
      if (i == MA) tl_frozen = exp_tl();
      push($sformatf("wrong_%0d", i),
           mk(exp_tl(), wh, i, i < MA, 0, i == MA, (i == MA) ? s_c : 7'd0));
      step();
    end
    push("eleventh_ignored", mk(tl_frozen, wh, MA, 0, 0, 1, s_c));
    step();
    guess_valid = 1'b0;

    // ---- round D: asynchronous reset mid-round, invalid difficulty ----
    difficulty = 2'd1; start = 1'b1; load_t = 30; elapsed = -1;
    push("start_d1", mk(30, 2'b00, 0, 1, 0, 0, 0));
    step();
    start = 1'b0;
    run(5);
    #3;
    rst = 1'b1;
    #1;
    push("async_reset_mid_round", mk(0, 2'b00, 0, 0, 0, 0, 0));
    check();
    step();
    rst = 1'b0;
    difficulty = 2'd0; start = 1'b1;
    push("start_d0_ignored", mk(0, 2'b00, 0, 0, 0, 0, 0));
    step();
    start = 1'b0;

    // ---- round E: correct guess on the final tick ---------------------
    difficulty = 2'd1; start = 1'b1; s_e = sec_of(m_lfsr);
    load_t = 30; elapsed = -1;
    push("fresh_start_after_reset", mk(30, 2'b00, 0, 1, 0, 0, 0));
    step();
    start = 1'b0;
    run(118);
    push("e_last_second", mk(1, 2'b00, 0, 1, 0, 0, 0));
    step();
    guess_valid = 1'b1; guess = s_e;
    push("win_on_final_tick", mk(0, 2'b11, 1, 0, 1, 0, s_e));
    step();
    guess_valid = 1'b0;

    // ---- round F: wrong tenth guess on the final tick -----------------
    difficulty = 2'd1; start = 1'b1; s_f = sec_of(m_lfsr);
    load_t = 30; elapsed = -1;
    push("start_round_f", mk(30, 2'b00, 0, 1, 0, 0, 0));
    step();
    start = 1'b0;
    wrong = (s_f == 7'd50) ? 7'd51 : 7'd50;
    wh    = (wrong < s_f) ? 2'b01 : 2'b10;
    guess_valid = 1'b1; guess = wrong;
    run(8);
    push("nine_wrong", mk(exp_tl(), wh, 9, 1, 0, 0, 0));
    step();
    guess_valid = 1'b0;
    run(109);
    push("f_last_second", mk(1, wh, 9, 1, 0, 0, 0));
    step();
    guess_valid = 1'b1;
    push("lose_on_final_tick", mk(0, wh, 10, 0, 0, 1, s_f));
    step();
    guess_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
